signed_addsub_pipe: RTL and testbench

Parametrised, pipelined signed two's-complement adder/subtractor with per-operation add/sub select, signed-overflow detection and valid/ready handshaking on both sides. It generalises the team's fixed 32-bit combinational signed adder. Operand width is a parameter, and the carry chain is split into CHUNK-bit slices, one register stage per slice, so wide operands close timing at full throughput. It sits between an operand-producing datapath and any consumer that can apply backpressure.

---
 rtl/signed_addsub_pipe.sv | 114 +++++++++++
 tb/tb_signed_addsub_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_addsub_pipe.sv
// Pipelined signed adder/subtractor: one CHUNK-bit slice of the carry chain per stage, valid/ready on both sides.
// Define SIGNED_ADDSUB_SAT_EN to saturate s_add on signed overflow instead of wrapping.
module signed_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_add,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $fatal(1, "signed_addsub_pipe: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // The whole pipe moves as one unit; a full output register blocks every stage.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Each stage narrows the unconsumed operand bits and widens the finished result bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * CHUNK;
    localparam int SW  = (k < STAGES - 1) ? CHUNK + 1 : CHUNK;

    logic [REM-1:0]         a_cur;
    logic [REM-1:0]         b_cur;
    logic                   c_cur;
    logic                   v_cur;
    logic [SW-1:0]          sum;
    logic [(k+1)*CHUNK-1:0] r_next;

    if (k == 0) begin : g_src
      assign a_cur  = num1;
      assign b_cur  = sub ? ~num2 : num2;
      assign c_cur  = sub;
      assign v_cur  = in_valid;
      assign r_next = sum[CHUNK-1:0];
    end else begin : g_src
      assign a_cur  = g_stage[k-1].g_reg.a_q;
      assign b_cur  = g_stage[k-1].g_reg.b_q;
      assign c_cur  = g_stage[k-1].g_reg.c_q;
      assign v_cur  = g_stage[k-1].g_reg.v_q;
      assign r_next = {sum[CHUNK-1:0], g_stage[k-1].g_reg.r_q};
    end

    assign sum = SW'(a_cur[CHUNK-1:0]) + SW'(b_cur[CHUNK-1:0]) + SW'(c_cur);

    if (k < STAGES - 1) begin : g_reg
      logic [REM-CHUNK-1:0]   a_q;
      logic [REM-CHUNK-1:0]   b_q;
      logic                   c_q;
      logic                   v_q;
      logic [(k+1)*CHUNK-1:0] r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
          r_q <= '0;
        end else if (en) begin
          a_q <= a_cur[REM-1:CHUNK];
          b_q <= b_cur[REM-1:CHUNK];
          c_q <= sum[CHUNK];
          v_q <= v_cur;
          r_q <= r_next;
        end
      end
    end else begin : g_out
      logic             a_sign;
      logic             b_sign;
      logic             ovf_next;
      logic [WIDTH-1:0] res_next;

      // The top slice still carries the operand sign bits, so overflow is judged here.
      assign a_sign   = a_cur[REM-1];
      assign b_sign   = b_cur[REM-1];
      assign ovf_next = (a_sign == b_sign) && (r_next[WIDTH-1] != a_sign);

`ifdef SIGNED_ADDSUB_SAT_EN
      assign res_next = !ovf_next ? r_next :
                        a_sign    ? {1'b1, {(WIDTH-1){1'b0}}} :
                                    {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign res_next = r_next;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          s_add     <= '0;
          ovf       <= 1'b0;
        end else if (en) begin
          out_valid <= v_cur;
          s_add     <= res_next;
          ovf       <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Bench for signed_addsub_pipe: directed streams, backpressure, reset flush, random traffic and a WIDTH=16/CHUNK=16 instance.
// Expected values follow SIGNED_ADDSUB_SAT_EN the same way the design does.
module tb_signed_addsub_pipe;

  localparam int     STAGES = 4;
  localparam longint MAXV   = 64'sd2147483647;
  localparam longint MINV   = -MAXV - 1;

`ifdef SIGNED_ADDSUB_SAT_EN
  localparam logic [15:0] EXP16_POS = 16'h7FFF;
  localparam logic [15:0] EXP16_NEG = 16'h8000;
`else
  localparam logic [15:0] EXP16_POS = 16'h8000;
  localparam logic [15:0] EXP16_NEG = 16'h7FFF;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, sub, out_valid, out_ready, ovf;
  logic [31:0] num1, num2, s_add;

  logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16, ovf16;
  logic [15:0] num1_16, num2_16, s_add16;

  typedef struct {
    logic [31:0] r;
    logic        o;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        accepted;
  logic [31:0] op_a[8];
  logic [31:0] op_b[8];
  logic        op_s[8];

  always #5 clk = ~clk;

  signed_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s_add(s_add), .ovf(ovf)
  );

  signed_addsub_pipe #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .num1(num1_16), .num2(num2_16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .s_add(s_add16), .ovf(ovf16)
  );

  // Reference: exact integer arithmetic, then range test, then wrap or clamp.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic o);
    longint sa, sbv, full;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    full = s ? sa - sbv : sa + sbv;
    o    = (full > MAXV) || (full < MINV);
    r    = full[31:0];
`ifdef SIGNED_ADDSUB_SAT_EN
    if (o) r = (full > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, check output side against the scoreboard, log any accept, advance.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic ordy);
    exp_t e;
    in_valid  = v;
    num1      = a;
    num2      = b;
    sub       = s;
    out_ready = ordy;
    #1;
    checkOutput("in_ready", in_ready, !out_valid || ordy);
    if (out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out", out_valid, 0);
      end else begin
        checkOutput("s_add", s_add, sb[0].r);
        checkOutput("ovf", ovf, sb[0].o);
        checkOutput("latency", cyc, sb[0].due);
        if (ordy) void'(sb.pop_front());
        else foreach (sb[i]) sb[i].due++;
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      checkOutput("missing_out", out_valid, 1);
    end
    accepted = v && in_ready;
    if (accepted) begin
      model(a, b, s, e.r, e.o);
      e.due = cyc + STAGES;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runStream(input int n, input int stall_from, input int stall_len);
    int   idx;
    logic ordy;
    idx = 0;
    for (int c = 0; c < 200 && (idx < n || sb.size() > 0); c++) begin
      ordy = !(c >= stall_from && c < stall_from + stall_len);
      if (idx < n) applyStimulus(1'b1, op_a[idx], op_b[idx], op_s[idx], ordy);
      else         applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, ordy);
      if (accepted) idx++;
    end
    checkOutput("stream_accepted", idx, n);
    checkOutput("stream_drained", sb.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    in_valid = 1'b0; num1 = '0; num2 = '0; sub = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; num1_16 = '0; num2_16 = '0; sub16 = 1'b0; out_ready16 = 1'b1;

    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_s_add", s_add, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid16", out_valid16, 0);
    checkOutput("rst_in_ready16", in_ready16, 1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Directed back-to-back stream, including the three overflow corners.
    op_a[0] = 32'd1010;        op_b[0] = 32'd1000;        op_s[0] = 1'b0;
    op_a[1] = -32'sd1001253;   op_b[1] = -32'sd263784;    op_s[1] = 1'b0;
    op_a[2] = 32'd263;         op_b[2] = 32'd27383;       op_s[2] = 1'b1;
    op_a[3] = -32'sd2526393;   op_b[3] = -32'sd5363;      op_s[3] = 1'b1;
    op_a[4] = 32'h7FFFFFFF;    op_b[4] = 32'd1;           op_s[4] = 1'b0;
    op_a[5] = 32'h80000000;    op_b[5] = 32'd1;           op_s[5] = 1'b1;
    op_a[6] = 32'd0;           op_b[6] = 32'h80000000;    op_s[6] = 1'b1;
    runStream(7, 0, 0);

    // Eight operations with a three-cycle output stall once results start flowing.
    for (int i = 0; i < 8; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
      op_s[i] = 1'($urandom_range(0, 1));
    end
    runStream(8, 4, 3);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), pick(), pick(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 40 && sb.size() > 0; i++)
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("random_drained", sb.size(), 0);

    // Three in flight, the oldest parked at the output, then reset.
    applyStimulus(1'b1, 32'd11, 32'd22, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd33, 32'd44, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd55, 32'd66, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_s_add", s_add, 0);
    checkOutput("async_rst_ovf", ovf, 0);
    checkOutput("async_rst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1;
    cyc++;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Single-stage instance: result visible right after the accepting edge.
    in_valid16 = 1'b1; num1_16 = 16'h7FFF; num2_16 = 16'd1; sub16 = 1'b0;
    #1;
    checkOutput("w16_in_ready", in_ready16, 1);
    @(posedge clk);
    #1;
    checkOutput("w16_pos_valid", out_valid16, 1);
    checkOutput("w16_pos_s_add", s_add16, EXP16_POS);
    checkOutput("w16_pos_ovf", ovf16, 1);
    num1_16 = 16'h8000; num2_16 = 16'd1; sub16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    checkOutput("w16_neg_valid", out_valid16, 1);
    checkOutput("w16_neg_s_add", s_add16, EXP16_NEG);
    checkOutput("w16_neg_ovf", ovf16, 1);
    @(posedge clk);
    #1;
    checkOutput("w16_idle_valid", out_valid16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
